// File: rtl/smem_row_scheduler.sv
// smem_row_scheduler
//   Round-robin arbiter that feeds 4*DW-bit rows from up to four requesters into
//   a single smem_writer_hsi. The winning row index and its four segments are
//   latched at grant time and held until the next grant. A flush fence reports
//   when every granted row has reached SMEM (writer idle and its FIFO empty).
//
// Ports
//   clk, reset            : single clock, synchronous active-high reset
//   req_valid/req_ack     : per-requester pending flag / one-cycle accept pulse
//   req_row_index         : requester k index at [k*32 +: 32]
//   req_data              : requester k segment s at [(k*4+s)*DW +: DW]
//   row_index, smem_data* : latched row presented to the writer
//   wr_start              : one-cycle start strobe to the writer
//   wr_ready, wr_done     : writer status (wr_done is CDC-synchronised, stale
//                           for DONE_GUARD cycles after a start)
//   flush_req/flush_done  : completion fence request / one-cycle completion
//   busy                  : scheduler not idle
//   rows_written          : rows handed to the writer, wraps at 2^32
module smem_row_scheduler #(
  parameter int DW         = 512,
  parameter int NREQ       = 2,
  parameter int DONE_GUARD = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ack,
  input  logic [NREQ*32-1:0]   req_row_index,
  input  logic [NREQ*4*DW-1:0] req_data,
  output logic [31:0]          row_index,
  output logic [DW-1:0]        smem_data0,
  output logic [DW-1:0]        smem_data1,
  output logic [DW-1:0]        smem_data2,
  output logic [DW-1:0]        smem_data3,
  output logic                 wr_start,
  input  logic                 wr_ready,
  input  logic                 wr_done,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic                 busy,
  output logic [31:0]          rows_written
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (DONE_GUARD > 0) ? $clog2(DONE_GUARD + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_BUSY
  } state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [31:0]           row_index_q, row_index_d;
  logic [3:0][DW-1:0]    seg_q, seg_d;
  logic [CW-1:0]         guard_q, guard_d;
  logic [31:0]           rows_written_q, rows_written_d;
  logic                  flush_pending_q, flush_pending_d;

  logic [GW-1:0]         cand;
  logic [GW-1:0]         winner;
  logic                  found;
  logic                  grant;
  logic                  flush_fire;

  // Round-robin search starting just after the last winner.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cand   = '0;
    winner = last_grant_q;
    found  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = GW'((int'(last_grant_q) + i) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // A flush request in the same cycle blocks the grant so the fence cannot be
  // overtaken by a row that arrived alongside it.
  assign grant      = (state_q == ST_IDLE) && wr_ready && found
                      && !flush_pending_q && !flush_req;
  assign flush_fire = (state_q == ST_IDLE) && (guard_q == '0) && wr_done
                      && flush_pending_q && !reset;

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    row_index_d     = row_index_q;
    seg_d           = seg_q;
    rows_written_d  = rows_written_q;
    guard_d         = (guard_q != '0) ? guard_q - CW'(1) : guard_q;
    flush_pending_d = flush_pending_q;

    if (flush_fire) begin
      flush_pending_d = 1'b0;
    end else if (flush_req) begin
      flush_pending_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d      = ST_START;
          last_grant_d = winner;
          row_index_d  = req_row_index[int'(winner)*32 +: 32];
          for (int s = 0; s < 4; s++) begin
            seg_d[s] = req_data[(int'(winner)*4 + s)*DW +: DW];
          end
        end
      end
      ST_START: begin
        guard_d        = CW'(DONE_GUARD);
        rows_written_d = rows_written_q + 32'd1;
        state_d        = ST_BUSY;
      end
      ST_BUSY: begin
        if (wr_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next-state value from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= GW'(NREQ - 1);
      row_index_q     <= '0;
      seg_q           <= '0;
      guard_q         <= '0;
      rows_written_q  <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      row_index_q     <= row_index_d;
      seg_q           <= seg_d;
      guard_q         <= guard_d;
      rows_written_q  <= rows_written_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  // Start and ack are suppressed while reset is asserted so a row whose START
  // cycle is cut off is never acknowledged and the requester keeps it.
  always_comb begin
    req_ack = '0;
    if (wr_start) begin
      req_ack[last_grant_q] = 1'b1;
    end
  end

  assign wr_start     = (state_q == ST_START) && !reset;
  assign flush_done   = flush_fire;
  assign busy         = (state_q != ST_IDLE);
  assign rows_written = rows_written_q;
  assign row_index    = row_index_q;
  assign smem_data0   = seg_q[0];
  assign smem_data1   = seg_q[1];
  assign smem_data2   = seg_q[2];
  assign smem_data3   = seg_q[3];

endmodule

// File: tb/tb_smem_row_scheduler.sv
// Self-checking bench for smem_row_scheduler (NREQ=3, DW=32, DONE_GUARD=16).
// Requesters and writer are small models; every granted row is predicted and
// queued when stimulus is applied, and popped/compared on each wr_start.
module tb_smem_row_scheduler;

  localparam int DW         = 32;
  localparam int NREQ       = 3;
  localparam int DONE_GUARD = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ack;
  logic [NREQ*32-1:0]   req_row_index;
  logic [NREQ*4*DW-1:0] req_data;
  logic [31:0]          row_index;
  logic [DW-1:0]        smem_data0, smem_data1, smem_data2, smem_data3;
  logic                 wr_start;
  logic                 wr_ready;
  logic                 wr_done;
  logic                 flush_req;
  logic                 flush_done;
  logic                 busy;
  logic [31:0]          rows_written;

  smem_row_scheduler #(.DW(DW), .NREQ(NREQ), .DONE_GUARD(DONE_GUARD)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ack      (req_ack),
    .req_row_index(req_row_index),
    .req_data     (req_data),
    .row_index    (row_index),
    .smem_data0   (smem_data0),
    .smem_data1   (smem_data1),
    .smem_data2   (smem_data2),
    .smem_data3   (smem_data3),
    .wr_start     (wr_start),
    .wr_ready     (wr_ready),
    .wr_done      (wr_done),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .busy         (busy),
    .rows_written (rows_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    int          n;
    logic [31:0] rw;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  bit          cur_valid;
  int          rem[NREQ];
  int          seq[NREQ];
  int          pseq[NREQ];
  logic [31:0] prw;
  int          writer_lat;
  int          wbusy;
  bit          scramble;
  int          cyc;
  int          grants;
  int          start_cyc;
  int          flush_cyc;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pat_idx(input int k, input int n);
    return 32'h12 + 32'(k) * 32'h1000 + 32'(n);
  endfunction

  function automatic logic [DW-1:0] pat_seg(input int k, input int n, input int s);
    return {8'(k), 8'(n), 8'(s), 8'hA5};
  endfunction

  task automatic push_exp(input int k);
    exp_t e;
    e.k = k;
    e.n = pseq[k];
    e.rw = prw;
    pseq[k]++;
    prw++;
    exp_q.push_back(e);
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < NREQ; k++) begin
      req_valid[k] = (rem[k] > 0);
      req_row_index[k*32 +: 32] = pat_idx(k, seq[k]) ^ {32{scramble}};
      for (int s = 0; s < 4; s++) begin
        req_data[(k*4 + s)*DW +: DW] = pat_seg(k, seq[k], s) ^ {DW{scramble}};
      end
    end
  endtask

  // Runs just after each rising edge: requesters retire acked rows and move
  // to their next row; the writer drops ready while busy with a row.
  task automatic update_models();
    for (int k = 0; k < NREQ; k++) begin
      if (req_ack[k] && rem[k] > 0) begin
        rem[k]--;
        seq[k]++;
      end
    end
    if (wr_start) begin
      wbusy    = writer_lat;
      wr_ready = 1'b0;
    end else if (wbusy > 0) begin
      wbusy--;
      if (wbusy == 0) wr_ready = 1'b1;
    end
    drive_reqs();
  endtask

  // Runs on the falling edge: scoreboard pop on wr_start, and the latched row
  // must match the last granted row on every cycle until the next grant.
  task automatic monitor();
    logic [NREQ-1:0] exp_ack;
    if (reset) begin
      cur_valid = 1'b0;
    end else begin
      if (wr_start) begin
        start_cyc = cyc;
        grants++;
        if (exp_q.size() == 0) begin
          check("start_without_expectation", wr_start, 1'b0);
        end else begin
          cur = exp_q.pop_front();
          cur_valid = 1'b1;
          exp_ack = NREQ'(1) << cur.k;
          check("req_ack", req_ack, exp_ack);
          check("rows_written_at_start", rows_written, cur.rw);
        end
      end else begin
        check("ack_outside_start", req_ack, '0);
      end
      if (flush_done) flush_cyc = cyc;
      if (cur_valid) begin
        check("row_index", row_index, pat_idx(cur.k, cur.n));
        check("smem_data0", smem_data0, pat_seg(cur.k, cur.n, 0));
        check("smem_data1", smem_data1, pat_seg(cur.k, cur.n, 1));
        check("smem_data2", smem_data2, pat_seg(cur.k, cur.n, 2));
        check("smem_data3", smem_data3, pat_seg(cur.k, cur.n, 3));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    update_models();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    cur_valid = 1'b0;
    prw = '0;
    exp_q.delete();
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_start"}, wr_start, 1'b0);
    check({tag, "_req_ack"}, req_ack, '0);
    check({tag, "_flush_done"}, flush_done, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_rows_written"}, rows_written, 32'd0);
    check({tag, "_row_index"}, row_index, 32'd0);
    check({tag, "_smem_data0"}, smem_data0, '0);
    check({tag, "_smem_data1"}, smem_data1, '0);
    check({tag, "_smem_data2"}, smem_data2, '0);
    check({tag, "_smem_data3"}, smem_data3, '0);
  endtask

  task automatic wait_start(input string tag);
    int g0 = grants;
    int n  = 0;
    while (grants == g0 && n < 100) begin
      step();
      n++;
    end
    check({tag, "_start_seen"}, 64'(grants - g0), 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      step();
      n++;
    end
    check({tag, "_rows_outstanding"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_busy_after_drain"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int s0;
    int n;
    reset = 1'b1;
    req_valid = '0;
    req_row_index = '0;
    req_data = '0;
    wr_ready = 1'b1;
    wr_done = 1'b0;
    flush_req = 1'b0;
    writer_lat = 3;
    wbusy = 0;
    scramble = 1'b0;
    cyc = 0;
    grants = 0;
    start_cyc = -1;
    flush_cyc = -1;
    n_checks = 0;
    n_errors = 0;
    cur_valid = 1'b0;
    prw = '0;
    for (int k = 0; k < NREQ; k++) begin
      rem[k] = 0;
      seq[k] = 0;
      pseq[k] = 0;
    end

    do_reset(3);
    check_reset_vals("por");

    // Single request from requester 0: ack/start one cycle after valid.
    rem[0] = 1;
    push_exp(0);
    drive_reqs();
    c0 = cyc;
    wait_start("single");
    check("grant_latency", 64'(start_cyc - c0), 64'd1);
    wait_drain("single");
    check("rows_written_single", rows_written, 32'd1);
    check("row_index_single", row_index, 32'h12);

    // Round robin: all three valid continuously for six grants.
    do_reset(2);
    for (int k = 0; k < NREQ; k++) rem[k] = 2;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NREQ; k++) push_exp(k);
    end
    drive_reqs();
    wait_drain("rr");
    check("rows_written_rr", rows_written, 32'd6);

    // Data hold: requester inputs scrambled through BUSY and the idle gap.
    rem[1] = 1;
    push_exp(1);
    drive_reqs();
    wait_start("hold");
    scramble = 1'b1;
    drive_reqs();
    repeat (8) step();
    scramble = 1'b0;
    drive_reqs();
    wait_drain("hold");

    // Flush with a stale wr_done: fence held off by the guard counter, and no
    // grants while it is pending even with two requesters valid.
    wr_done = 1'b1;
    rem[0] = 1;
    push_exp(0);
    drive_reqs();
    wait_start("flush_stale");
    s0 = start_cyc;
    flush_req = 1'b1;
    rem[0] = 1;
    rem[1] = 1;
    drive_reqs();
    flush_cyc = -1;
    step();
    flush_req = 1'b0;
    n = 0;
    while (flush_cyc < 0 && n < 100) begin
      step();
      n++;
    end
    check("flush_not_before_guard", 64'(flush_cyc - s0 >= DONE_GUARD), 64'd1);
    check("flush_stale_latency", 64'(flush_cyc - s0), 64'(DONE_GUARD + 1));
    push_exp(1);
    push_exp(0);
    wait_drain("flush_rows");
    repeat (20) step();

    // Flush and request in the same idle cycle: flush first, grant after.
    flush_req = 1'b1;
    rem[0] = 1;
    push_exp(0);
    drive_reqs();
    c0 = cyc;
    flush_cyc = -1;
    step();
    flush_req = 1'b0;
    wait_drain("flush_vs_req");
    check("flush_first_latency", 64'(flush_cyc - c0), 64'd1);
    check("grant_after_flush", 64'(start_cyc - c0), 64'd3);
    wr_done = 1'b0;

    // Reset while BUSY, then the first grant goes to requester 0.
    rem[2] = 1;
    push_exp(2);
    drive_reqs();
    wait_start("mid_row");
    check("busy_before_reset", busy, 1'b1);
    do_reset(1);
    check_reset_vals("mid_row");
    for (int k = 0; k < NREQ; k++) begin
      rem[k] = 1;
      push_exp(k);
    end
    drive_reqs();
    wait_drain("after_reset");

    // Row counter wrap from all-ones to zero.
    force dut.rows_written_q = 32'hFFFF_FFFF;
    step();
    release dut.rows_written_q;
    prw = 32'hFFFF_FFFF;
    rem[1] = 1;
    push_exp(1);
    drive_reqs();
    wait_drain("wrap");
    check("rows_written_wrap", rows_written, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
